// File: rtl/lemon_pkg.sv
// Shared constants and types for the LemonPC execute core: ALU selects,
// opcode/funct encodings and the decode bundle.
package lemon_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned INST_W    = 32;
  localparam int unsigned MASK_W    = XLEN / 8;
  localparam int unsigned ALU_SEL_W = 4;

  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_sel_e;

  localparam logic [6:0]        OPC_OP_IMM  = 7'b0010011;
  localparam logic [INST_W-1:0] INST_EBREAK = 32'h0010_0073;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [5:0] F6_LOGIC = 6'b000000;
  localparam logic [5:0] F6_ARITH = 6'b010000;

  typedef struct packed {
    alu_sel_e sel;
    logic     legal;
    logic     op_imm;
    logic     ebreak;
  } dec_t;

endpackage

// File: rtl/lemon_exec_core_if.sv
// Fetch, decode and data-port signals between the LemonPC top level and the core.
interface lemon_exec_core_if;
  import lemon_pkg::*;

  logic [XLEN-1:0]   inst_addr;
  logic [INST_W-1:0] inst;
  logic [XLEN-1:0]   rs1_data;
  logic [4:0]        rs1;
  logic [4:0]        rd;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   alu_res;
  logic              reg_wen;
  logic              illegal;
  logic              halt;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic [MASK_W-1:0] d_wmask;
  logic              d_wen;
  logic [XLEN-1:0]   d_rdata;

  modport master (
    output inst_addr, rs1_data, d_addr, d_wdata, d_wmask, d_wen,
    input  inst, rs1, rd, imm, alu_res, reg_wen, illegal, halt, d_rdata
  );

  modport slave (
    input  inst_addr, rs1_data, d_addr, d_wdata, d_wmask, d_wen,
    output inst, rs1, rd, imm, alu_res, reg_wen, illegal, halt, d_rdata
  );
endinterface

// File: rtl/lemon_alu.sv
// Combinational ALU: a op b, shift amount from the low bits of b.
module lemon_alu
  import lemon_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_sel_e     sel,
  output logic [W-1:0] res_c
);
  localparam int unsigned SH_W = $clog2(W);

  logic [SH_W-1:0] sh;
  assign sh = b[SH_W-1:0];

  always_comb begin
    res_c = '0;
    case (sel)
      ALU_ADD:  res_c = a + b;
      ALU_SUB:  res_c = a - b;
      ALU_AND:  res_c = a & b;
      ALU_OR:   res_c = a | b;
      ALU_XOR:  res_c = a ^ b;
      ALU_SLL:  res_c = a << sh;
      ALU_SRL:  res_c = a >> sh;
      ALU_SRA:  res_c = W'($signed(a) >>> sh);
      ALU_SLT:  res_c = W'($signed(a) < $signed(b));
      ALU_SLTU: res_c = W'(a < b);
      default:  res_c = '0;
    endcase
  end
endmodule

// File: rtl/lemon_mem.sv
// Doubleword memory: 32-bit fetch port, 64-bit data read port, byte-masked write port.
module lemon_mem
  import lemon_pkg::*;
#(
  parameter int unsigned     DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic              clk,
  input  logic [XLEN-1:0]   fetch_addr,
  output logic [INST_W-1:0] fetch_data_c,
  input  logic [XLEN-1:0]   addr,
  output logic [XLEN-1:0]   rdata_c,
  input  logic [XLEN-1:0]   wdata,
  input  logic [MASK_W-1:0] wmask,
  input  logic              wen
);
  localparam int unsigned   AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [XLEN-1:0] SPAN = XLEN'(DEPTH_WORDS) << 3;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  function automatic logic in_range(input logic [XLEN-1:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [XLEN-1:0] a);
    logic [XLEN-1:0] off;
    off = a - BASE_ADDR;
    return AW'(off >> 3);
  endfunction

  // Unaligned reads shift the containing doubleword down, zero-filling the top.
  always_comb begin
    fetch_data_c = '0;
    if (in_range(fetch_addr))
      fetch_data_c = INST_W'(mem[word_idx(fetch_addr)] >> {fetch_addr[2:0], 3'b000});
  end

  always_comb begin
    rdata_c = '0;
    if (in_range(addr))
      rdata_c = mem[word_idx(addr)] >> {addr[2:0], 3'b000};
  end

  // Contents deliberately survive reset; the caller gates wen with reset.
  always_ff @(posedge clk) begin
    if (wen && in_range(addr)) begin
      for (int b = 0; b < int'(MASK_W); b++) begin
        if (wmask[b]) mem[word_idx(addr)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: rtl/lemon_exec_core.sv
// LemonPC single-cycle execute core: fetch, OP-IMM/EBREAK decode, ALU and sticky halt.
module lemon_exec_core
  import lemon_pkg::*;
#(
  parameter int unsigned     DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = 64'h8000_0000
) (
  input logic               clk,
  input logic               rst_n,
  lemon_exec_core_if.slave  bus
);
  logic [INST_W-1:0] inst;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   alu_out;
  logic              halt;
  dec_t              dec;

  lemon_mem #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .BASE_ADDR   (BASE_ADDR)
  ) u_mem (
    .clk          (clk),
    .fetch_addr   (bus.inst_addr),
    .fetch_data_c (inst),
    .addr         (bus.d_addr),
    .rdata_c      (bus.d_rdata),
    .wdata        (bus.d_wdata),
    .wmask        (bus.d_wmask),
    .wen          (bus.d_wen & rst_n)
  );

  assign imm = {{(XLEN-12){inst[31]}}, inst[31:20]};

  // Decode: only OP-IMM and EBREAK are legal; shifts also qualify funct6.
  always_comb begin
    dec = '{sel: ALU_ADD, legal: 1'b0, op_imm: 1'b0, ebreak: 1'b0};
    if (inst == INST_EBREAK) begin
      dec.legal  = 1'b1;
      dec.ebreak = 1'b1;
    end else if (inst[6:0] == OPC_OP_IMM) begin
      dec.op_imm = 1'b1;
      dec.legal  = 1'b1;
      case (inst[14:12])
        F3_ADD:  dec.sel = ALU_ADD;
        F3_SLT:  dec.sel = ALU_SLT;
        F3_SLTU: dec.sel = ALU_SLTU;
        F3_XOR:  dec.sel = ALU_XOR;
        F3_OR:   dec.sel = ALU_OR;
        F3_AND:  dec.sel = ALU_AND;
        F3_SLL: begin
          if (inst[31:26] == F6_LOGIC) dec.sel = ALU_SLL;
          else                         dec.legal = 1'b0;
        end
        F3_SR: begin
          if (inst[31:26] == F6_LOGIC)      dec.sel = ALU_SRL;
          else if (inst[31:26] == F6_ARITH) dec.sel = ALU_SRA;
          else                              dec.legal = 1'b0;
        end
      endcase
    end
  end

  lemon_alu #(.W(XLEN)) u_alu (
    .a     (bus.rs1_data),
    .b     (imm),
    .sel   (dec.sel),
    .res_c (alu_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          halt <= 1'b0;
    else if (dec.ebreak) halt <= 1'b1;
  end

  assign bus.inst    = inst;
  assign bus.rs1     = inst[19:15];
  assign bus.rd      = inst[11:7];
  assign bus.imm     = imm;
  assign bus.alu_res = dec.legal ? alu_out : '0;
  assign bus.reg_wen = dec.op_imm & dec.legal & ~halt;
  assign bus.illegal = ~dec.legal;
  assign bus.halt    = halt;
endmodule

// File: tb/tb_lemon_exec_core.sv
// Directed plus randomized bench for lemon_exec_core against an instruction/memory reference model.
module tb_lemon_exec_core;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [63:0] LAST  = BASE + 64'd8184;
  localparam logic [31:0] EBRK  = 32'h0010_0073;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lemon_exec_core_if bus();

  lemon_exec_core #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int compared = 0;
  int mismatched = 0;
  logic [63:0] mdl [4:15];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mem_wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
    @(negedge clk);
    bus.d_addr  = a;
    bus.d_wdata = d;
    bus.d_wmask = m;
    bus.d_wen   = 1'b1;
    @(posedge clk);
    #1 bus.d_wen = 1'b0;
  endtask

  // Reference: RV64 OP-IMM semantics on rs1 and the sign-extended immediate.
  function automatic void ref_exec(input logic [31:0] i, input logic [63:0] r1,
                                   output logic ill, output logic wen, output logic [63:0] res);
    logic [63:0] im;
    int sh;
    im  = {{52{i[31]}}, i[31:20]};
    sh  = int'(im[5:0]);
    ill = 1'b1;
    wen = 1'b0;
    res = 64'd0;
    if (i == EBRK) begin
      ill = 1'b0;
    end else if (i[6:0] == 7'h13) begin
      ill = 1'b0;
      case (i[14:12])
        3'd0: res = r1 + im;
        3'd2: res = ($signed(r1) < $signed(im)) ? 64'd1 : 64'd0;
        3'd3: res = (r1 < im) ? 64'd1 : 64'd0;
        3'd4: res = r1 ^ im;
        3'd6: res = r1 | im;
        3'd7: res = r1 & im;
        3'd1: if (i[31:26] == 6'd0) res = r1 << sh; else ill = 1'b1;
        3'd5: begin
          if (i[31:26] == 6'd0)            res = r1 >> sh;
          else if (i[31:26] == 6'b010000) res = 64'($signed(r1) >>> sh);
          else                            ill = 1'b1;
        end
      endcase
      wen = ~ill;
      if (ill) res = 64'd0;
    end
  endfunction

  task automatic exec(input logic [31:0] i, input logic [63:0] r1, input bit hi, input string tag);
    logic ill, wen;
    logic [63:0] res;
    bus.inst_addr = BASE;
    mem_wr(BASE + 64'd24, hi ? {i, 32'h0} : {32'h0, i}, hi ? 8'hF0 : 8'h0F);
    bus.inst_addr = BASE + 64'd24 + (hi ? 64'd4 : 64'd0);
    bus.rs1_data  = r1;
    #1;
    ref_exec(i, r1, ill, wen, res);
    chk({tag, ".inst"},    64'(bus.inst), 64'(i));
    chk({tag, ".illegal"}, 64'(bus.illegal), 64'(ill));
    chk({tag, ".reg_wen"}, 64'(bus.reg_wen), 64'(wen));
    chk({tag, ".alu_res"}, bus.alu_res, res);
    chk({tag, ".rd"},      64'(bus.rd), 64'(i[11:7]));
    chk({tag, ".rs1"},     64'(bus.rs1), 64'(i[19:15]));
    chk({tag, ".imm"},     bus.imm, {{52{i[31]}}, i[31:20]});
  endtask

  initial begin
    logic [31:0] ins;
    logic [63:0] r1, d, exp;
    logic [11:0] imm12;
    logic [5:0]  f6;
    logic [2:0]  f3;
    logic [7:0]  m;
    int k, off;

    bus.inst_addr = BASE - 64'd8;
    bus.rs1_data  = 64'd0;
    bus.d_addr    = BASE - 64'd8;
    bus.d_wdata   = 64'd0;
    bus.d_wmask   = 8'h00;
    bus.d_wen     = 1'b0;
    #1 chk("reset.halt", 64'(bus.halt), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Preload and ADDI x1,x0,5
    mem_wr(BASE, 64'h0010_0073_0050_0093, 8'hFF);
    bus.inst_addr = BASE;
    bus.rs1_data  = 64'd7;
    #1;
    chk("addi.inst",    64'(bus.inst), 64'h0050_0093);
    chk("addi.rd",      64'(bus.rd), 64'd1);
    chk("addi.imm",     bus.imm, 64'd5);
    chk("addi.alu_res", bus.alu_res, 64'd12);
    chk("addi.reg_wen", 64'(bus.reg_wen), 64'd1);
    chk("addi.illegal", 64'(bus.illegal), 64'd0);

    mem_wr(BASE + 64'd8, {32'h0, 32'hFFF0_0093}, 8'hFF);
    bus.inst_addr = BASE + 64'd8;
    bus.rs1_data  = 64'd0;
    #1;
    chk("addi_m1.imm", bus.imm, '1);
    chk("addi_m1.alu", bus.alu_res, '1);
    bus.inst_addr = BASE;

    // Byte mask and unaligned data reads
    mem_wr(BASE + 64'd16, '1, 8'hFF);
    mem_wr(BASE + 64'd16, 64'd0, 8'h0F);
    bus.d_addr = BASE + 64'd16;
    #1 chk("mask.rdata", bus.d_rdata, 64'hFFFF_FFFF_0000_0000);
    bus.d_addr = BASE + 64'd20;
    #1 chk("mask.rdata_off4", bus.d_rdata, 64'h0000_0000_FFFF_FFFF);

    // Range boundaries
    mem_wr(LAST, 64'h1234_5678_9ABC_DEF0, 8'hFF);
    bus.d_addr = LAST;
    #1 chk("range.last_word", bus.d_rdata, 64'h1234_5678_9ABC_DEF0);
    bus.d_addr = BASE + 64'd8192;
    #1 chk("range.past_end", bus.d_rdata, 64'd0);
    bus.d_addr = 64'h7FFF_FFF8;
    #1 chk("range.below_base", bus.d_rdata, 64'd0);
    mem_wr(64'h7FFF_FFF8, '1, 8'hFF);
    bus.d_addr = 64'h7FFF_FFF8;
    #1 chk("range.below_after_wr", bus.d_rdata, 64'd0);
    bus.d_addr = LAST;
    #1 chk("range.last_untouched", bus.d_rdata, 64'h1234_5678_9ABC_DEF0);
    bus.d_addr = BASE;
    #1 chk("range.word0_untouched", bus.d_rdata, 64'h0010_0073_0050_0093);

    // Shift and compare corners
    exec({6'b010000, 6'd63, 5'd1, 3'b101, 5'd2, 7'h13}, 64'h8000_0000_0000_0000, 1'b0, "srai63");
    chk("srai63.ones", bus.alu_res, '1);
    exec({6'b000000, 6'd63, 5'd1, 3'b101, 5'd2, 7'h13}, 64'h8000_0000_0000_0000, 1'b1, "srli63");
    chk("srli63.one", bus.alu_res, 64'd1);
    exec({12'd0, 5'd1, 3'b010, 5'd2, 7'h13}, 64'h8000_0000_0000_0000, 1'b0, "slti0");
    chk("slti0.one", bus.alu_res, 64'd1);
    exec({12'd0, 5'd1, 3'b011, 5'd2, 7'h13}, 64'h8000_0000_0000_0000, 1'b1, "sltiu0");
    chk("sltiu0.zero", bus.alu_res, 64'd0);

    // Illegal R-type encoding
    exec(32'h0000_0033, 64'hDEAD_BEEF, 1'b0, "illegal");
    chk("illegal.flag", 64'(bus.illegal), 64'd1);
    chk("illegal.alu", bus.alu_res, 64'd0);
    @(posedge clk);
    #1 chk("illegal.halt", 64'(bus.halt), 64'd0);

    // Random instructions
    for (int n = 0; n < 150; n++) begin
      f3 = 3'($urandom_range(0, 7));
      imm12 = 12'($urandom);
      if (f3 == 3'd1 || f3 == 3'd5) begin
        case ($urandom_range(0, 3))
          0, 1:    f6 = 6'd0;
          2:       f6 = 6'b010000;
          default: f6 = 6'($urandom);
        endcase
        imm12 = {f6, 6'($urandom)};
      end
      ins = {imm12, 5'($urandom), f3, 5'($urandom), 7'h13};
      if ($urandom_range(0, 9) == 0) ins[6:0] = 7'($urandom);
      if (ins == EBRK) ins[20] = 1'b0;
      case ($urandom_range(0, 3))
        0:       r1 = 64'h8000_0000_0000_0000;
        1:       r1 = '1;
        default: r1 = {32'($urandom), 32'($urandom)};
      endcase
      exec(ins, r1, 1'($urandom), $sformatf("rnd%0d", n));
    end

    // Random masked writes to a window, checked against a byte model
    for (int w = 4; w <= 15; w++) begin
      mdl[w] = {32'($urandom), 32'($urandom)};
      mem_wr(BASE + 64'(8 * w), mdl[w], 8'hFF);
    end
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(4, 15);
      d = {32'($urandom), 32'($urandom)};
      m = 8'($urandom);
      mem_wr(BASE + 64'(8 * k), d, m);
      for (int b = 0; b < 8; b++) if (m[b]) mdl[k][8*b +: 8] = d[8*b +: 8];
      bus.d_addr = BASE + 64'(8 * k);
      #1 chk($sformatf("mwr%0d", n), bus.d_rdata, mdl[k]);
    end
    for (int n = 0; n < 30; n++) begin
      k = $urandom_range(4, 15);
      off = $urandom_range(0, 7);
      bus.d_addr = BASE + 64'(8 * k + off);
      exp = mdl[k] >> (8 * off);
      #1 chk($sformatf("mrd%0d", n), bus.d_rdata, exp);
    end

    // Read-during-write sees old data until the edge
    @(negedge clk);
    bus.d_addr  = BASE + 64'd32;
    bus.d_wdata = ~mdl[4];
    bus.d_wmask = 8'hFF;
    bus.d_wen   = 1'b1;
    #1 chk("rdw.old", bus.d_rdata, mdl[4]);
    @(posedge clk);
    #1 bus.d_wen = 1'b0;
    mdl[4] = ~mdl[4];
    chk("rdw.new", bus.d_rdata, mdl[4]);

    // EBREAK and sticky halt
    @(negedge clk);
    bus.inst_addr = BASE + 64'd4;
    #1;
    chk("ebreak.inst",    64'(bus.inst), 64'(EBRK));
    chk("ebreak.reg_wen", 64'(bus.reg_wen), 64'd0);
    chk("ebreak.illegal", 64'(bus.illegal), 64'd0);
    chk("ebreak.pre_halt", 64'(bus.halt), 64'd0);
    @(posedge clk);
    #1 chk("ebreak.halt", 64'(bus.halt), 64'd1);
    @(negedge clk);
    bus.inst_addr = BASE;
    bus.rs1_data  = 64'd7;
    repeat (3) @(posedge clk);
    #1;
    chk("halted.halt", 64'(bus.halt), 64'd1);
    chk("halted.reg_wen", 64'(bus.reg_wen), 64'd0);
    chk("halted.alu_res", bus.alu_res, 64'd12);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset.async_clear", 64'(bus.halt), 64'd0);

    // Writes during reset are ignored
    bus.d_addr  = BASE + 64'd32;
    bus.d_wdata = ~mdl[4];
    bus.d_wmask = 8'hFF;
    bus.d_wen   = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.d_wen = 1'b0;
    chk("reset.halt_held", 64'(bus.halt), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("reset.wr_ignored", bus.d_rdata, mdl[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/lemon_exec_core.md
# lemon_exec_core

Combinational execute and decode core with an embedded byte-maskable 64-bit memory for the LemonPC single-cycle RV64 prototype. It fetches a 32-bit instruction at a given PC and decodes the OP-IMM group and EBREAK. It computes the ALU result of `rs1_data` op sign-extended immediate and exposes a data port for preloading or inspecting memory. It sits between the PC register and the register file. The surrounding top level owns the PC and the GPRs.

## Interface
- `DEPTH_WORDS`, default 1024: number of 64-bit memory words.
- `BASE_ADDR`, default 64'h8000_0000: byte address of word 0.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `inst_addr` input 64: fetch address (PC).
- `inst` output 32: fetched instruction.
- `rs1_data` input 64: register-file value of `rs1`.
- `rs1` output 5: `inst[19:15]`.
- `rd` output 5: `inst[11:7]`.
- `imm` output 64: `inst[31:20]` sign-extended.
- `alu_res` output 64: ALU result.
- `reg_wen` output 1: writeback enable for `rd`.
- `illegal` output 1: the current instruction is not supported.
- `halt` output 1: sticky flag set by EBREAK.
- `d_addr` input 64: data port byte address.
- `d_wdata` input 64: data port write data.
- `d_wmask` input 8: byte enables; bit i enables byte i.
- `d_wen` input 1: data port write strobe.
- `d_rdata` output 64: data port read data.

## Operation
Memory array:
- Indexing: word index = (addr − `BASE_ADDR`) >> 3.
- In range: `BASE_ADDR` ≤ addr < `BASE_ADDR` + 8·`DEPTH_WORDS`.
- Read, in range: the aligned doubleword, logically shifted right by 8·addr[2:0] with zero fill.
- Read, out of range: returns 0.
- `inst` = read(`inst_addr`)[31:0], so a PC at offset 4 returns the upper half of the word.
- `d_rdata` = read(`d_addr`).
- Write: to the aligned word at `d_addr`, updating only bytes whose `d_wmask` bit is set.
- Out-of-range writes are dropped.
- Memory contents are not cleared by reset.

Decode (`control`):
- Supported: opcode 7'b0010011 (OP-IMM) and EBREAK (32'h0010_0073).
- funct3 to ALU op:
  - 000 ADD
  - 010 SLT
  - 011 SLTU
  - 100 XOR
  - 110 OR
  - 111 AND
  - 001 SLL, requires `inst[31:26]` = 0
  - 101 SRL when `inst[31:26]` = 0; SRA when `inst[31:26]` = 6'b010000
- `reg_wen` = 1 for a supported OP-IMM instruction while `halt` = 0; otherwise 0.
- `illegal` = 1 for any other encoding, including bad shift funct6. EBREAK is legal.
- When `illegal` = 1, `alu_res` = 0.

ALU (`alu`), A = `rs1_data`, B = `imm`, 4-bit sel:
- 0 ADD
- 1 SUB
- 2 AND
- 3 OR
- 4 XOR
- 5 SLL
- 6 SRL
- 7 SRA
- 8 SLT (signed)
- 9 SLTU
- 10–15 give 0.
- Shift amount is B[5:0]. Compare results are zero-extended to 64 bits.
- Arithmetic wraps modulo 2^64.

## Timing
- `inst`, decode outputs, `alu_res` and `d_rdata` are combinational, with zero latency from inputs.
- Memory write commits on the rising edge of `clk` when `d_wen` = 1 and `rst_n` = 1.
- Read-during-write returns the old data until the edge.
- `halt`:
  - Cleared asynchronously when `rst_n` = 0 (reset value 0).
  - Set on the rising edge where `inst` is EBREAK.
  - Stays set until the next reset.
- Outputs during reset: `halt` = 0; all other outputs follow the combinational rules from the current inputs and memory.
- Writes presented while `rst_n` = 0 are ignored.

## Structure
Shared package `lemon_pkg`:
- ALU sel encodings
- OP-IMM opcode, EBREAK constant
- funct3 and funct6 values

Sub-modules:
- `lemon_alu`: pure combinational, parameterised width.
- `lemon_mem`: two read ports, one masked write port.
- Decode and the `halt` flop stay in the top module.

## Test plan
- Reset then preload: `rst_n` = 0 → `halt` = 0. Release reset, write `d_addr` = 0x8000_0000, `d_wdata` = 0x0010_0073_0050_0093, `d_wmask` = 0xFF. Then `inst_addr` = 0x8000_0000 → `inst` = 0x0050_0093.
- ADDI: `rs1_data` = 7 with that instruction (addi x1,x0,5) → `rd` = 1, `imm` = 5, `alu_res` = 12, `reg_wen` = 1. With `imm` = 0xFFF (−1) and `rs1_data` = 0 → `alu_res` = all ones.
- EBREAK: `inst_addr` = 0x8000_0004 → `inst` = 0x0010_0073, `reg_wen` = 0. After one edge `halt` = 1, and it stays 1. Asserting `rst_n` = 0 clears it immediately.
- Byte mask: write 0xFFFF…FF, then `d_wdata` = 0, `d_wmask` = 0x0F → `d_rdata` = 0xFFFF_FFFF_0000_0000. Out-of-range `d_addr` = 0x7FFF_FFF8 reads 0 and writes have no effect.
- ALU ops via OP-IMM, `rs1_data` = 0x8000_0000_0000_0000:
  - srai by 63 → all ones
  - srli by 63 → 1
  - slti imm 0 → 1
  - sltiu imm 0 → 0
- Illegal: `inst` = 0x0000_0033 → `illegal` = 1, `reg_wen` = 0, `alu_res` = 0, `halt` unchanged.
